spi_req_arbiter: RTL and testbench

- Shares one SPI master (`start`/`din_m`/`cpol`/`cpha`/`dvsr` in, `done_m`/`dout_m` out) among N_REQ requesters.
- Round-robin arbitration per transaction; a transaction is one or more bytes.
- Owns per-requester active-low slave selects with setup/hold spacing.
- Latches each winner's SPI mode and divider, and aborts via a watchdog if the master never reports done.

---
 rtl/spi_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_spi_req_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master among N_REQ requesters.
// It drives the slave selects with setup/hold spacing, supports locked multi-byte bursts and has a done watchdog.
module spi_req_arbiter #(
   parameter int N_REQ    = 4,
   parameter int SS_SETUP = 2,
   parameter int SS_HOLD  = 2,
   parameter int TIMEOUT  = 20000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ-1:0]      lock,
   input  logic [8*N_REQ-1:0]    wdata,
   input  logic [N_REQ-1:0]      cpol_i,
   input  logic [N_REQ-1:0]      cpha_i,
   input  logic [16*N_REQ-1:0]   dvsr_i,
   output logic [N_REQ-1:0]      gnt,
   output logic [N_REQ-1:0]      ack,
   output logic [N_REQ-1:0]      err,
   output logic [7:0]            rdata,
   output logic [N_REQ-1:0]      ss_n,
   output logic                  m_start,
   output logic [7:0]            m_din,
   output logic                  m_cpol,
   output logic                  m_cpha,
   output logic [15:0]           m_dvsr,
   input  logic                  m_done,
   input  logic [7:0]            m_dout
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = (SS_SETUP > 1) ? $clog2(SS_SETUP) : 1;
   localparam int HW = (SS_HOLD > 1) ? $clog2(SS_HOLD) : 1;

   localparam logic [TW-1:0] WD_LAST    = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] WD_MAX     = TW'(TIMEOUT);
   localparam logic [SW-1:0] SETUP_LAST = SW'(SS_SETUP - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(SS_HOLD - 1);
   localparam logic [PW-1:0] LAST_IDX   = PW'(N_REQ - 1);

   typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, RESP, HOLD} state_t;

   state_t            state;
   logic [PW-1:0]     rr;
   logic [PW-1:0]     own;
   logic [SW-1:0]     scnt;
   logic [HW-1:0]     hcnt;
   logic [TW-1:0]     wdog;

   logic              win_vld;
   logic [PW-1:0]     win_idx;
   logic [N_REQ-1:0]  win_oh;
   logic [PW-1:0]     nxt_rr;

   // Lowest offset from rr wins, so scan from the far end and let nearer hits overwrite.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[(int'(rr) + k) % N_REQ]) begin
            win_vld = 1'b1;
            win_idx = PW'((int'(rr) + k) % N_REQ);
         end
      end
      win_oh = N_REQ'(1) << win_idx;
      nxt_rr = (own == LAST_IDX) ? '0 : own + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         rr      <= '0;
         own     <= '0;
         scnt    <= '0;
         hcnt    <= '0;
         wdog    <= '0;
         gnt     <= '0;
         ack     <= '0;
         err     <= '0;
         rdata   <= '0;
         ss_n    <= '1;
         m_start <= 1'b0;
         m_din   <= '0;
         m_cpol  <= 1'b0;
         m_cpha  <= 1'b0;
         m_dvsr  <= '0;
      end else begin
         ack     <= '0;
         err     <= '0;
         m_start <= 1'b0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  own    <= win_idx;
                  gnt    <= win_oh;
                  ss_n   <= ~win_oh;
                  m_cpol <= cpol_i[win_idx];
                  m_cpha <= cpha_i[win_idx];
                  m_dvsr <= dvsr_i[16*int'(win_idx) +: 16];
                  scnt   <= '0;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               if (scnt == SETUP_LAST) state <= START;
               else                    scnt  <= scnt + 1'b1;
            end
            START: begin
               m_din   <= wdata[8*int'(own) +: 8];
               m_start <= 1'b1;
               wdog    <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               if (m_done) begin
                  rdata <= m_dout;
                  ack   <= gnt;
                  state <= RESP;
               end else if (wdog == WD_LAST) begin
                  // Abort ends the burst regardless of lock.
                  err   <= gnt;
                  gnt   <= '0;
                  ss_n  <= '1;
                  rr    <= nxt_rr;
                  hcnt  <= '0;
                  state <= HOLD;
               end else if (wdog != WD_MAX) begin
                  wdog <= wdog + 1'b1;
               end
            end
            RESP: begin
               if (lock[own] && req[own]) begin
                  state <= START;
               end else begin
                  gnt   <= '0;
                  ss_n  <= '1;
                  rr    <= nxt_rr;
                  hcnt  <= '0;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (hcnt == HOLD_LAST) state <= IDLE;
               else                   hcnt  <= hcnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter with a simple master model whose slave returns the TX byte XOR 8'h19.
module tb_spi_req_arbiter;

   localparam int N    = 4;
   localparam int MLAT = 5;
   localparam int WMAX = 300;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req, lock, cpol_i, cpha_i;
   logic [8*N-1:0]  wdata;
   logic [16*N-1:0] dvsr_i;
   logic [N-1:0]    gnt, ack, err, ss_n;
   logic [7:0]      rdata, m_din, m_dout;
   logic            m_start, m_cpol, m_cpha, m_done;
   logic [15:0]     m_dvsr;

   logic            mdead;
   int              mcnt;
   logic [7:0]      mpend;
   int              n_chk, n_err;
   logic            mon_en, ss2_rel, g0_early;

   spi_req_arbiter #(.N_REQ(N), .SS_SETUP(2), .SS_HOLD(2), .TIMEOUT(100)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
      .cpol_i(cpol_i), .cpha_i(cpha_i), .dvsr_i(dvsr_i),
      .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .ss_n(ss_n),
      .m_start(m_start), .m_din(m_din), .m_cpol(m_cpol), .m_cpha(m_cpha),
      .m_dvsr(m_dvsr), .m_done(m_done), .m_dout(m_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   // Master model: m_done MLAT cycles after m_start unless mdead.
   initial begin
      m_done = 1'b0;
      m_dout = 8'h00;
      mcnt   = 0;
      mpend  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         m_done = 1'b0;
         if (!rst) begin
            mcnt = 0;
         end else if (mcnt != 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0 && !mdead) begin
               m_done = 1'b1;
               m_dout = mpend;
            end
         end else if (m_start) begin
            mpend = m_din ^ 8'h19;
            mcnt  = MLAT;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (ss_n[2]) ss2_rel <= 1'b1;
         if (gnt[0])  g0_early <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output int n);
      n = 0;
      while (gnt == '0 && n < WMAX) begin tick(); n++; end
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (!m_start && n < WMAX) begin tick(); n++; end
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      while (ack == '0 && n < WMAX) begin tick(); n++; end
   endtask

   logic [7:0] exp_rd [5];
   int         n, hi;
   logic       ack_seen;

   initial begin
      n_chk = 0; n_err = 0;
      rst = 1'b0; req = '0; lock = '0; wdata = '0;
      cpol_i = '0; cpha_i = '0; dvsr_i = '0; mdead = 1'b0;
      mon_en = 1'b0; ss2_rel = 1'b0; g0_early = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_gnt",   32'(gnt),     32'(4'b0000));
      chk("rst_ssn",   32'(ss_n),    32'(4'b1111));
      chk("rst_ack",   32'(ack),     32'(4'b0000));
      chk("rst_err",   32'(err),     32'(4'b0000));
      chk("rst_start", 32'(m_start), 32'(1'b0));
      chk("rst_rdata", 32'(rdata),   32'(8'h00));
      chk("rst_dvsr",  32'(m_dvsr),  32'(16'h0000));
      rst = 1'b1;

      // Single request from requester 1
      wdata[15:8] = 8'h93; dvsr_i[31:16] = 16'd49; req = 4'b0010;
      tick();
      chk("t1_gnt", 32'(gnt),  32'(4'b0010));
      chk("t1_ssn", 32'(ss_n), 32'(4'b1101));
      n = 1;
      while (!m_start && n < 50) begin tick(); n++; end
      chk("t1_lat",  32'(n),      32'(4));
      chk("t1_din",  32'(m_din),  32'(8'h93));
      chk("t1_dvsr", 32'(m_dvsr), 32'(16'd49));
      chk("t1_mode", 32'({m_cpol, m_cpha}), 32'(2'b00));
      wait_ack(n);
      chk("t1_acklat", 32'(n),     32'(MLAT + 1));
      chk("t1_ack",    32'(ack),   32'(4'b0010));
      chk("t1_rdata",  32'(rdata), 32'(8'h8A));
      chk("t1_ssn_ack", 32'(ss_n), 32'(4'b1101));
      req = '0;
      tick();
      chk("t1_ssn_rel", 32'(ss_n), 32'(4'b1111));
      chk("t1_gnt_rel", 32'(gnt),  32'(4'b0000));
      tick(); tick(); tick();

      // Round robin from a fresh reset
      rst = 1'b0; tick(); rst = 1'b1;
      wdata = {8'h13, 8'h12, 8'h11, 8'h10};
      exp_rd = '{8'h09, 8'h08, 8'h0B, 8'h0A, 8'h09};
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         hi = 0; n = 0;
         while (gnt == '0 && n < WMAX) begin
            if (ss_n == 4'b1111) hi++;
            tick(); n++;
         end
         chk($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
         if (k > 0) chk($sformatf("t2_hold%0d", k), 32'(hi >= 2), 32'(1));
         wait_ack(n);
         chk($sformatf("t2_ack%0d", k), 32'(ack), 32'(4'b0001 << (k % 4)));
         chk($sformatf("t2_rd%0d", k), 32'(rdata), 32'(exp_rd[k]));
         if (k == 4) req = '0;
         tick();
      end
      tick(); tick(); tick();

      // Locked burst on requester 2 while requester 0 waits
      wdata[23:16] = 8'h01; wdata[7:0] = 8'h55; lock = 4'b0100; req = 4'b0100;
      wait_gnt(n);
      chk("t3_gnt", 32'(gnt), 32'(4'b0100));
      req[0] = 1'b1; ss2_rel = 1'b0; g0_early = 1'b0; mon_en = 1'b1;
      wait_start(n);
      chk("t3_din1", 32'(m_din), 32'(8'h01));
      wait_ack(n);
      chk("t3_rd1", 32'(rdata), 32'(8'h18));
      wdata[23:16] = 8'h02;
      wait_start(n);
      chk("t3_b2b", 32'(n), 32'(2));
      chk("t3_din2", 32'(m_din), 32'(8'h02));
      wait_ack(n);
      chk("t3_rd2", 32'(rdata), 32'(8'h1B));
      wdata[23:16] = 8'h03;
      tick();
      lock = '0;
      wait_start(n);
      chk("t3_din3", 32'(m_din), 32'(8'h03));
      wait_ack(n);
      chk("t3_ack3", 32'(ack),   32'(4'b0100));
      chk("t3_rd3",  32'(rdata), 32'(8'h1A));
      req[2] = 1'b0;
      mon_en = 1'b0;
      chk("t3_ss2_low", 32'(ss2_rel),  32'(1'b0));
      chk("t3_g0_wait", 32'(g0_early), 32'(1'b0));
      tick();
      wait_gnt(n);
      chk("t3_gnt0", 32'(gnt), 32'(4'b0001));
      wait_ack(n);
      chk("t3_rd0", 32'(rdata), 32'(8'h4C));
      req = '0;
      tick(); tick(); tick(); tick();

      // Mode latch on requester 3
      cpol_i[3] = 1'b1; cpha_i[3] = 1'b1; dvsr_i[63:48] = 16'd9; wdata[31:24] = 8'hC3;
      req = 4'b1000;
      wait_gnt(n);
      chk("t4_gnt", 32'(gnt), 32'(4'b1000));
      wait_start(n);
      tick();
      cpol_i[3] = 1'b0; cpha_i[3] = 1'b0; dvsr_i[63:48] = 16'd77;
      tick();
      chk("t4_mode_wait", 32'({m_cpol, m_cpha}), 32'(2'b11));
      wait_ack(n);
      chk("t4_mode_ack", 32'({m_cpol, m_cpha}), 32'(2'b11));
      chk("t4_dvsr",     32'(m_dvsr), 32'(16'd9));
      chk("t4_rd",       32'(rdata),  32'(8'hDA));
      req = '0;
      tick(); tick(); tick(); tick();

      // Watchdog abort on requester 0, then requester 1 served
      mdead = 1'b1; wdata[15:8] = 8'h93; req = 4'b0011;
      wait_gnt(n);
      chk("t5_gnt", 32'(gnt), 32'(4'b0001));
      wait_start(n);
      n = 0; ack_seen = 1'b0;
      while (err == '0 && n < WMAX) begin
         tick(); n++;
         if (ack != '0) ack_seen = 1'b1;
      end
      chk("t5_lat",   32'(n),        32'(100));
      chk("t5_err",   32'(err),      32'(4'b0001));
      chk("t5_noack", 32'(ack_seen), 32'(1'b0));
      chk("t5_ssn",   32'(ss_n),     32'(4'b1111));
      req[0] = 1'b0; mdead = 1'b0;
      tick();
      chk("t5_errpulse", 32'(err), 32'(4'b0000));
      wait_gnt(n);
      chk("t5_next", 32'(gnt), 32'(4'b0010));
      wait_ack(n);
      chk("t5_rd1", 32'(rdata), 32'(8'h8A));
      req = '0;
      tick(); tick(); tick(); tick();

      // Reset in WAIT: pointer would favour requester 2, reset restores requester 0
      req = 4'b0101;
      wait_gnt(n);
      chk("t6_gnt2", 32'(gnt), 32'(4'b0100));
      wait_start(n);
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("t6_gnt",   32'(gnt),     32'(4'b0000));
      chk("t6_ssn",   32'(ss_n),    32'(4'b1111));
      chk("t6_ackerr", 32'({ack, err}), 32'(8'h00));
      chk("t6_start", 32'(m_start), 32'(1'b0));
      chk("t6_din",   32'(m_din),   32'(8'h00));
      chk("t6_mode",  32'({m_cpol, m_cpha, m_dvsr}), 32'(18'h0));
      tick();
      chk("t6_fresh", 32'(gnt), 32'(4'b0001));
      wait_ack(n);
      chk("t6_ack0", 32'(ack),   32'(4'b0001));
      chk("t6_rd0",  32'(rdata), 32'(8'h4C));
      req = '0;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
